serial_word_add_sub: RTL and testbench
======================================

Name: serial_word_add_sub

Overview:
- Digit-serial two's-complement adder/subtractor for words of WORD_W bits, fed LSB-digit first, DIGIT_W bits per beat.
- Successor to the 1-bit serial adder: adds word framing, add/sub mode, configurable digit width, registered outputs, end-of-word carry/overflow flags and protocol-error detection.
- Sits between bit/digit-serial datapaths (serialisers, serial MAC chains) in sequential-basics designs.

Parameters:
- WORD_W, 16, word length in bits; must be a multiple of DIGIT_W.
- DIGIT_W, 1, bits consumed per valid beat; NDIG = WORD_W/DIGIT_W digits per word, NDIG >= 2.

Ports:
- clk  input  1  clock, all state on posedge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  digit present on a/b this cycle.
- in_first  input  1  qualifies in_valid; marks digit 0 (LSB) of a word.
- sub  input  1  sampled only on first digit; 1 = a-b, 0 = a+b.
- a  input  DIGIT_W  operand A digit.
- b  input  DIGIT_W  operand B digit.
- out_valid  output  1  result digit valid.
- sum  output  DIGIT_W  result digit.
- out_last  output  1  with out_valid, marks final (MSB) digit.
- carry_out  output  1  valid only with out_last: carry out of bit WORD_W-1 (sub: 1 = no borrow).
- overflow  output  1  valid only with out_last: signed overflow.
- proto_err  output  1  one-cycle pulse on framing violation.

Behaviour:
- State: IDLE / RUN; digit counter idx (0..NDIG-1); carry register; latched mode sub_q.
- Reset: state IDLE, idx 0, carry 0, sub_q 0; all outputs 0.
- Per digit: b_eff = sub_q ? ~b : b; {c_next, s} = a + b_eff + c_in, computed with XOR/AND/OR ripple across DIGIT_W bits, no + operator.
- c_in = sub on a first digit, else the carry register.
- Overflow: carry into bit DIGIT_W-1 of the last digit XOR c_next.
- Latency: exactly 1 cycle. Outputs are registered; accepted digit k at cycle t appears at t+1 with out_valid=1.
- out_valid deasserts the cycle after a non-accepted cycle. Outputs other than out_valid hold value when out_valid=0; only valid-qualified values are checked.
- in_valid=0: no state change; gaps of any length allowed mid-word.
- IDLE + in_valid + in_first:
  - latch sub_q = sub, process digit 0, idx <= 1, go to RUN.
  - Exception, NDIG=1 is illegal, so no same-cycle completion.
- IDLE + in_valid + !in_first: digit dropped, no output, proto_err pulses next cycle.
- RUN + in_valid + !in_first: process digit idx, increment idx.
  - When idx = NDIG-1: out_last, carry_out and overflow are set on that output; state returns to IDLE, idx 0, carry 0.
- RUN + in_valid + in_first (premature restart):
  - abandon current word, which produces no out_last; proto_err pulses.
  - New word starts as in IDLE; its digit 0 is output normally.
- sub changes off a first digit are ignored.
- Reset mid-word: word discarded, no further outputs. Reset dominates all inputs in the same cycle.
- Back-to-back words: first digit of word N+1 may arrive the cycle after the last digit of word N, with no bubble.

Test Plan:
- WORD_W=8, DIGIT_W=1, add 0x5A+0x27, 8 contiguous beats -> sum bits LSB-first form 0x81; out_last on 8th output; carry_out=0; overflow=1.
- WORD_W=8, DIGIT_W=1, sub 0x10-0x20 -> 0xF0, carry_out=0 (borrow), overflow=0. Then sub 0x20-0x10 back-to-back -> 0x10, carry_out=1, overflow=0; no bubble between words.
- WORD_W=8, DIGIT_W=4, add 0x7F+0x01 with a 3-cycle in_valid gap between digits -> out digits 0x0, 0x8 (0x80); overflow=1; carry_out=0; out_valid only on the 2 accepted beats +1.
- WORD_W=16, DIGIT_W=4, add 0xFFFF+0x0001 -> 0x0000, carry_out=1, overflow=0. Then sub 0x8000-0x0001 -> 0x7FFF, overflow=1, carry_out=1.
- Framing: IDLE digit without in_first -> no out_valid, proto_err=1 one cycle. In RUN after 3 digits, assert in_first -> proto_err pulse, no out_last for the aborted word, new word 0x0003+0x0004=0x0007 completes correctly.
- Assert rst after 2 digits of a word, then start a fresh word 0x0A+0x05 (WORD_W=8, DIGIT_W=1) -> outputs 0 during reset, result 0x0F with carry starting from 0, no stale carry.

Source files
------------

// File: rtl/serial_word_add_sub_if.sv
// Digit-serial add/sub bus: operand digits and framing in, result digits and flags out.
// master drives operands and framing; slave is the adder/subtractor.
interface serial_word_add_sub_if #(
  parameter int DIGIT_W = 1
);
  logic               in_valid;
  logic               in_first;
  logic               sub;
  logic [DIGIT_W-1:0] a;
  logic [DIGIT_W-1:0] b;
  logic               out_valid;
  logic [DIGIT_W-1:0] sum;
  logic               out_last;
  logic               carry_out;
  logic               overflow;
  logic               proto_err;

  modport master (
    output in_valid, in_first, sub, a, b,
    input  out_valid, sum, out_last, carry_out, overflow, proto_err
  );

  modport slave (
    input  in_valid, in_first, sub, a, b,
    output out_valid, sum, out_last, carry_out, overflow, proto_err
  );
endinterface

// File: rtl/serial_word_add_sub.sv
// Digit-serial two's-complement adder/subtractor, LSB digit first, one-cycle registered latency.
// Words are framed by in_first; framing violations raise a one-cycle proto_err pulse.
module serial_word_add_sub #(
  parameter int WORD_W  = 16,
  parameter int DIGIT_W = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  serial_word_add_sub_if.slave bus
);
  localparam int NDIG  = WORD_W / DIGIT_W;
  localparam int IDX_W = $clog2(NDIG);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NDIG - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_ZERO = IDX_W'(0);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Ripple add returning {carry into MSB, carry out, sum}; the MSB carry-in feeds overflow.
  function automatic logic [DIGIT_W+1:0] digit_add(
    input logic [DIGIT_W-1:0] x,
    input logic [DIGIT_W-1:0] y,
    input logic               c_in
  );
    logic [DIGIT_W-1:0] s;
    logic               c;
    logic               c_msb;
    s     = {DIGIT_W{1'b0}};
    c     = c_in;
    c_msb = 1'b0;
    for (int i = 0; i < DIGIT_W; i++) begin
      c_msb = c;
      s[i]  = x[i] ^ y[i] ^ c;
      c     = (x[i] & y[i]) | (x[i] & c) | (y[i] & c);
    end
    return {c_msb, c, s};
  endfunction

  state_t             state_r, state_s;
  logic [IDX_W-1:0]   idx_r, idx_s, idx_cur_s;
  logic               carry_r, carry_s;
  logic               sub_q_r, sub_q_s;
  logic               start_s, accept_s, last_s, err_s;
  logic               sub_eff_s, c_in_s;
  logic [DIGIT_W-1:0] b_eff_s;
  logic [DIGIT_W+1:0] add_s;

  logic               out_valid_r;
  logic [DIGIT_W-1:0] sum_r;
  logic               out_last_r;
  logic               carry_out_r;
  logic               overflow_r;
  logic               proto_err_r;

  // FSM state, digit index, running carry and latched mode.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      idx_r   <= IDX_ZERO;
      carry_r <= 1'b0;
      sub_q_r <= 1'b0;
    end else begin
      state_r <= state_s;
      idx_r   <= idx_s;
      carry_r <= carry_s;
      sub_q_r <= sub_q_s;
    end
  end

  // Acceptance, datapath and next-state; any in_first restarts the word from digit 0.
  always_comb begin
    start_s  = bus.in_valid & bus.in_first;
    accept_s = 1'b0;
    err_s    = 1'b0;
    case (state_r)
      IDLE: begin
        accept_s = start_s;
        err_s    = bus.in_valid & ~bus.in_first;
      end
      RUN: begin
        accept_s = bus.in_valid;
        err_s    = start_s;
      end
      default: begin
        accept_s = 1'b0;
        err_s    = 1'b0;
      end
    endcase

    idx_cur_s = start_s ? IDX_ZERO : idx_r;
    last_s    = accept_s & (idx_cur_s == IDX_LAST);
    sub_eff_s = start_s ? bus.sub : sub_q_r;
    c_in_s    = start_s ? bus.sub : carry_r;
    b_eff_s   = sub_eff_s ? ~bus.b : bus.b;
    add_s     = digit_add(bus.a, b_eff_s, c_in_s);

    state_s = state_r;
    idx_s   = idx_r;
    carry_s = carry_r;
    sub_q_s = sub_q_r;
    if (start_s) begin
      state_s = RUN;
      idx_s   = IDX_ONE;
      carry_s = add_s[DIGIT_W];
      sub_q_s = bus.sub;
    end else if (last_s) begin
      state_s = IDLE;
      idx_s   = IDX_ZERO;
      carry_s = 1'b0;
    end else if (accept_s) begin
      idx_s   = idx_r + IDX_ONE;
      carry_s = add_s[DIGIT_W];
    end else begin
      state_s = state_r;
      idx_s   = idx_r;
    end
  end

  // Registered outputs; data fields hold their value between accepted digits.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      sum_r       <= {DIGIT_W{1'b0}};
      out_last_r  <= 1'b0;
      carry_out_r <= 1'b0;
      overflow_r  <= 1'b0;
      proto_err_r <= 1'b0;
    end else begin
      out_valid_r <= accept_s;
      proto_err_r <= err_s;
      if (accept_s) begin
        sum_r       <= add_s[DIGIT_W-1:0];
        out_last_r  <= last_s;
        carry_out_r <= add_s[DIGIT_W];
        overflow_r  <= add_s[DIGIT_W+1] ^ add_s[DIGIT_W];
      end
    end
  end

  assign bus.out_valid = out_valid_r;
  assign bus.sum       = sum_r;
  assign bus.out_last  = out_last_r;
  assign bus.carry_out = carry_out_r;
  assign bus.overflow  = overflow_r;
  assign bus.proto_err = proto_err_r;
endmodule

// File: tb/tb_serial_word_add_sub.sv
// Directed bench for serial_word_add_sub in 8x1, 8x4 and 16x4 configurations.
module tb_serial_word_add_sub;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests_run    = 0;
  int   tests_failed = 0;

  serial_word_add_sub_if #(.DIGIT_W(1)) i81 ();
  serial_word_add_sub_if #(.DIGIT_W(4)) i84 ();
  serial_word_add_sub_if #(.DIGIT_W(4)) i164 ();

  serial_word_add_sub #(.WORD_W(8),  .DIGIT_W(1)) u_8x1  (.clk(clk), .rst(rst), .bus(i81));
  serial_word_add_sub #(.WORD_W(8),  .DIGIT_W(4)) u_8x4  (.clk(clk), .rst(rst), .bus(i84));
  serial_word_add_sub #(.WORD_W(16), .DIGIT_W(4)) u_16x4 (.clk(clk), .rst(rst), .bus(i164));

  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Off-first sub toggles must be ignored by the DUT.
  task automatic w8x1(input string tag, input logic [7:0] opa, input logic [7:0] opb, input logic mode,
                      input logic [7:0] exp_s, input logic exp_c, input logic exp_o);
    logic [7:0] got;
    got = 8'h00;
    for (int k = 0; k < 8; k++) begin
      i81.in_valid = 1'b1;
      i81.in_first = (k == 0);
      i81.sub      = (k == 0) ? mode : ~mode;
      i81.a        = opa[k];
      i81.b        = opb[k];
      tick();
      check_value({tag, ".vld"}, {31'd0, i81.out_valid}, 32'd1);
      check_value({tag, ".last"}, {31'd0, i81.out_last}, {31'd0, (k == 7)});
      got[k] = i81.sum[0];
    end
    i81.in_valid = 1'b0;
    i81.in_first = 1'b0;
    check_value({tag, ".sum"}, {24'd0, got}, {24'd0, exp_s});
    check_value({tag, ".cout"}, {31'd0, i81.carry_out}, {31'd0, exp_c});
    check_value({tag, ".ovf"}, {31'd0, i81.overflow}, {31'd0, exp_o});
  endtask

  task automatic w8x4(input string tag, input logic [7:0] opa, input logic [7:0] opb, input logic mode,
                      input int gap, input logic [7:0] exp_s, input logic exp_c, input logic exp_o);
    logic [7:0] got;
    got = 8'h00;
    for (int k = 0; k < 2; k++) begin
      i84.in_valid = 1'b1;
      i84.in_first = (k == 0);
      i84.sub      = mode;
      i84.a        = opa[k*4 +: 4];
      i84.b        = opb[k*4 +: 4];
      tick();
      check_value({tag, ".vld"}, {31'd0, i84.out_valid}, 32'd1);
      check_value({tag, ".last"}, {31'd0, i84.out_last}, {31'd0, (k == 1)});
      got[k*4 +: 4] = i84.sum;
      i84.in_valid = 1'b0;
      i84.in_first = 1'b0;
      if (k == 0) begin
        for (int g = 0; g < gap; g++) begin
          tick();
          check_value({tag, ".gap"}, {31'd0, i84.out_valid}, 32'd0);
        end
      end
    end
    check_value({tag, ".sum"}, {24'd0, got}, {24'd0, exp_s});
    check_value({tag, ".cout"}, {31'd0, i84.carry_out}, {31'd0, exp_c});
    check_value({tag, ".ovf"}, {31'd0, i84.overflow}, {31'd0, exp_o});
  endtask

  task automatic w16x4(input string tag, input logic [15:0] opa, input logic [15:0] opb, input logic mode,
                       input logic perr0, input logic [15:0] exp_s, input logic exp_c, input logic exp_o);
    logic [15:0] got;
    got = 16'h0000;
    for (int k = 0; k < 4; k++) begin
      i164.in_valid = 1'b1;
      i164.in_first = (k == 0);
      i164.sub      = mode;
      i164.a        = opa[k*4 +: 4];
      i164.b        = opb[k*4 +: 4];
      tick();
      check_value({tag, ".vld"}, {31'd0, i164.out_valid}, 32'd1);
      check_value({tag, ".last"}, {31'd0, i164.out_last}, {31'd0, (k == 3)});
      check_value({tag, ".perr"}, {31'd0, i164.proto_err}, {31'd0, (k == 0) ? perr0 : 1'b0});
      got[k*4 +: 4] = i164.sum;
    end
    i164.in_valid = 1'b0;
    i164.in_first = 1'b0;
    check_value({tag, ".sum"}, {16'd0, got}, {16'd0, exp_s});
    check_value({tag, ".cout"}, {31'd0, i164.carry_out}, {31'd0, exp_c});
    check_value({tag, ".ovf"}, {31'd0, i164.overflow}, {31'd0, exp_o});
  endtask

  initial begin
    i81.in_valid = 1'b0;  i81.in_first = 1'b0;  i81.sub = 1'b0;  i81.a = 1'b0;  i81.b = 1'b0;
    i84.in_valid = 1'b0;  i84.in_first = 1'b0;  i84.sub = 1'b0;  i84.a = 4'h0;  i84.b = 4'h0;
    i164.in_valid = 1'b0; i164.in_first = 1'b0; i164.sub = 1'b0; i164.a = 4'h0; i164.b = 4'h0;

    repeat (3) tick();
    check_value("rst.vld",  {31'd0, i81.out_valid}, 32'd0);
    check_value("rst.last", {31'd0, i81.out_last}, 32'd0);
    check_value("rst.perr", {31'd0, i164.proto_err}, 32'd0);
    check_value("rst.sum",  {28'd0, i164.sum}, 32'd0);
    rst = 1'b0;
    tick();

    w8x1("add5a27", 8'h5A, 8'h27, 1'b0, 8'h81, 1'b0, 1'b1);
    w8x1("sub1020", 8'h10, 8'h20, 1'b1, 8'hF0, 1'b0, 1'b0);
    w8x1("sub2010", 8'h20, 8'h10, 1'b1, 8'h10, 1'b1, 1'b0);

    w8x4("add7f01", 8'h7F, 8'h01, 1'b0, 3, 8'h80, 1'b0, 1'b1);

    w16x4("addffff", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    w16x4("sub8000", 16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1);

    // Stray digit while idle.
    i164.in_valid = 1'b1; i164.in_first = 1'b0; i164.a = 4'hF; i164.b = 4'hF;
    tick();
    check_value("idle.vld",  {31'd0, i164.out_valid}, 32'd0);
    check_value("idle.perr", {31'd0, i164.proto_err}, 32'd1);
    i164.in_valid = 1'b0;
    tick();
    check_value("idle.perr_end", {31'd0, i164.proto_err}, 32'd0);

    // Three digits, then a premature in_first.
    for (int k = 0; k < 3; k++) begin
      i164.in_valid = 1'b1; i164.in_first = (k == 0); i164.sub = 1'b0;
      i164.a = 4'h1; i164.b = 4'h2;
      tick();
      check_value("abort.last", {31'd0, i164.out_last}, 32'd0);
      check_value("abort.perr", {31'd0, i164.proto_err}, 32'd0);
    end
    w16x4("restart", 16'h0003, 16'h0004, 1'b0, 1'b1, 16'h0007, 1'b0, 1'b0);

    // Reset mid-word with a pending carry, then a fresh word.
    for (int k = 0; k < 2; k++) begin
      i81.in_valid = 1'b1; i81.in_first = (k == 0); i81.sub = 1'b0;
      i81.a = 1'b1; i81.b = 1'b1;
      tick();
    end
    rst = 1'b1;
    i81.in_valid = 1'b1; i81.in_first = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tick();
      check_value("mrst.vld",  {31'd0, i81.out_valid}, 32'd0);
      check_value("mrst.sum",  {31'd0, i81.sum[0]}, 32'd0);
      check_value("mrst.perr", {31'd0, i81.proto_err}, 32'd0);
      check_value("mrst.cout", {31'd0, i81.carry_out}, 32'd0);
    end
    rst = 1'b0;
    i81.in_valid = 1'b0;
    tick();
    check_value("mrst.idle", {31'd0, i81.out_valid}, 32'd0);
    w8x1("add0a05", 8'h0A, 8'h05, 1'b0, 8'h0F, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
